bkt_lvl_ctrl: RTL and testbench
===============================

// Module: bkt_lvl_ctrl
// PURPOSE
//  Sequencer for the Sat Engine level-state store (dcd_bin + has_bkt per level).
//  Records decisions into the store. On request, walks levels from max_lvl down to 1.
//  Finds the highest level whose has_bkt is 0, marks it backtracked and reports
//  bkt_lvl/bkt_bin. Reports unsat when every level 1..max_lvl is already backtracked.
//  Sole master of the store's read and write ports.
// PARAMETERS
//  WIDTH_LVL         16  level number width
//  WIDTH_BIN         10  bin number width
//  WIDTH_LVL_STATES  11  store entry width = WIDTH_BIN+1; entry = {dcd_bin, has_bkt}
//  MAX_LVL           64  highest level held in the store
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 synchronous reset, active-high
//  dec_valid_i      in   1                 record decision at dec_lvl_i
//  dec_ready_o      out  1                 decision accepted (= ~busy_o)
//  dec_lvl_i        in   WIDTH_LVL         decision level (1..MAX_LVL)
//  dec_bin_i        in   WIDTH_BIN         bin holding the decided var
//  start_i          in   1                 begin find-backtrack-level
//  max_lvl_i        in   WIDTH_LVL         top level to scan
//  abort_i          in   1                 cancel scan, no write
//  busy_o           out  1                 FSM not in IDLE
//  done_o           out  1                 1-cycle pulse, result valid
//  unsat_o          out  1                 no unbacktracked level found
//  bkt_lvl_o        out  WIDTH_LVL         found level (0 when unsat)
//  bkt_bin_o        out  WIDTH_BIN         dcd_bin of found level (0 when unsat)
//  apply_bkt_o      out  1                 1-cycle pulse, backtrack committed
//  rd_en_o          out  1                 store read strobe
//  rd_addr_o        out  WIDTH_LVL         store read level
//  rd_data_i        in   WIDTH_LVL_STATES  read data, valid exactly 1 cycle after rd_en_o
//  wr_en_o          out  1                 store write strobe
//  wr_addr_o        out  WIDTH_LVL         store write level
//  wr_data_o        out  WIDTH_LVL_STATES  store write data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except dec_ready_o=1; results cleared.
//  FSM states: IDLE, RD, CHK, APPLY, DONE.
//   IDLE
//    - start_i: latch m = min(max_lvl_i, MAX_LVL); lvl <= m.
//    - Go to RD if m != 0. If m == 0, go to DONE with unsat_o=1, bkt_lvl_o=0.
//   RD
//    - rd_en_o=1, rd_addr_o=lvl. Go to CHK.
//   CHK
//    - Sample rd_data_i.
//    - If has_bkt==0: bkt_lvl_o=lvl, bkt_bin_o=rd_data_i[WIDTH_LVL_STATES-1:1], unsat_o=0; go to APPLY.
//    - Else if lvl==1: unsat_o=1, bkt_lvl_o=0, bkt_bin_o=0; go to DONE.
//    - Else lvl <= lvl-1; go to RD.
//   APPLY
//    - wr_en_o=1, wr_addr_o=bkt_lvl_o, wr_data_o={bkt_bin_o,1'b1}, apply_bkt_o=1. Go to DONE.
//   DONE
//    - done_o=1 for 1 cycle. Go to IDLE.
//    - bkt_lvl_o, bkt_bin_o and unsat_o hold until the next start_i.
//  Decisions
//    - Accepted only in IDLE (dec_ready_o=1).
//    - Same-cycle write: wr_en_o=1, wr_addr_o=dec_lvl_i, wr_data_o={dec_bin_i,1'b0}.
//    - dec_valid_i while busy: ignored, no write; the requester must hold it.
//    - dec_lvl_i==0 or >MAX_LVL: dropped, no write.
//  Simultaneous dec_valid_i and start_i in IDLE: both accepted; the decision write
//    lands before the first RD, so the scan sees it.
//  Latency from start_i (cycle 0):
//    - found after checking k levels: apply_bkt_o at cycle 2k+1, done_o at 2k+2.
//    - unsat with m levels: done_o at cycle 2m+1.
//    - m==0: done_o at cycle 1.
//  abort_i in RD/CHK: next state IDLE, no write, no done_o, results unchanged.
//    abort_i in APPLY/DONE: ignored.
//  start_i while busy: ignored.
//  rst mid-scan: returns to IDLE same edge, no store write issued.
//  At most one of rd_en_o / wr_en_o is high in any cycle.
// TESTING
//  1. Reset -> busy_o=0, done_o=0, wr_en_o=0, dec_ready_o=1; store model unchanged.
//  2. has_bkt L1..L3={0,1,1}, bins L1=5; start max_lvl=3 -> reads L3,L2,L1; apply_bkt_o @c7;
//     write L1={5,1}; done_o @c8 with bkt_lvl=1, bkt_bin=5.
//  3. has_bkt L1..L2 all 1; start max_lvl=2 -> done_o @c5, unsat_o=1, bkt_lvl_o=0, no write.
//  4. max_lvl=0 -> done_o @c1 unsat_o=1.
//     max_lvl=200 with MAX_LVL=64 -> first rd_addr_o=64.
//  5. dec_valid lvl=4 bin=9 same cycle as start max_lvl=4 -> write {9,0} to L4 first;
//     scan finds L4 (bkt_bin_o=9), done_o @c4.
//  6. abort_i in CHK -> IDLE next cycle, no apply_bkt_o, no done_o.
//     rst mid-scan -> IDLE, no store write.

Source files
------------

// File: rtl/bkt_lvl_ctrl.sv
// Backtrack-level sequencer for the Sat Engine level-state store.
// Records decisions and scans levels downward for the highest level not yet backtracked.
module bkt_lvl_ctrl #(
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN        = 10,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int MAX_LVL          = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid_i,
  output logic                        dec_ready_o,
  input  logic [WIDTH_LVL-1:0]        dec_lvl_i,
  input  logic [WIDTH_BIN-1:0]        dec_bin_i,
  input  logic                        start_i,
  input  logic [WIDTH_LVL-1:0]        max_lvl_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        unsat_o,
  output logic [WIDTH_LVL-1:0]        bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]        bkt_bin_o,
  output logic                        apply_bkt_o,
  output logic                        rd_en_o,
  output logic [WIDTH_LVL-1:0]        rd_addr_o,
  input  logic [WIDTH_LVL_STATES-1:0] rd_data_i,
  output logic                        wr_en_o,
  output logic [WIDTH_LVL-1:0]        wr_addr_o,
  output logic [WIDTH_LVL_STATES-1:0] wr_data_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CHK   = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH_LVL-1:0] MAX_LVL_W = WIDTH_LVL'(MAX_LVL);
  localparam logic [WIDTH_LVL-1:0] LVL_ONE   = WIDTH_LVL'(1);

  state_t               state_q, state_d;
  logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_BIN-1:0] bkt_bin_q, bkt_bin_d;
  logic                 unsat_q, unsat_d;

  logic [WIDTH_LVL-1:0] scan_top;
  logic                 dec_in_range;
  logic                 rd_has_bkt;
  logic [WIDTH_BIN-1:0] rd_bin;

  function automatic logic [WIDTH_LVL-1:0] clamp_lvl(input logic [WIDTH_LVL-1:0] lvl);
    return (lvl > MAX_LVL_W) ? MAX_LVL_W : lvl;
  endfunction

  assign scan_top     = clamp_lvl(max_lvl_i);
  assign dec_in_range = (dec_lvl_i != '0) && (dec_lvl_i <= MAX_LVL_W);
  assign rd_has_bkt   = rd_data_i[0];
  assign rd_bin       = rd_data_i[WIDTH_LVL_STATES-1:1];

  assign busy_o      = (state_q != S_IDLE);
  assign dec_ready_o = ~busy_o;
  assign bkt_lvl_o   = bkt_lvl_q;
  assign bkt_bin_o   = bkt_bin_q;
  assign unsat_o     = unsat_q;

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    bkt_lvl_d   = bkt_lvl_q;
    bkt_bin_d   = bkt_bin_q;
    unsat_d     = unsat_q;
    rd_en_o     = 1'b0;
    rd_addr_o   = '0;
    wr_en_o     = 1'b0;
    wr_addr_o   = '0;
    wr_data_o   = '0;
    apply_bkt_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The decision write goes out this cycle, so a scan started alongside it sees the new entry.
        if (dec_valid_i && dec_in_range) begin
          wr_en_o   = 1'b1;
          wr_addr_o = dec_lvl_i;
          wr_data_o = {dec_bin_i, 1'b0};
        end
        if (start_i) begin
          lvl_d = scan_top;
          if (scan_top == '0) begin
            unsat_d   = 1'b1;
            bkt_lvl_d = '0;
            bkt_bin_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rd_en_o   = 1'b1;
        rd_addr_o = lvl_q;
        state_d   = abort_i ? S_IDLE : S_CHK;
      end
      S_CHK: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!rd_has_bkt) begin
          bkt_lvl_d = lvl_q;
          bkt_bin_d = rd_bin;
          unsat_d   = 1'b0;
          state_d   = S_APPLY;
        end else if (lvl_q == LVL_ONE) begin
          unsat_d   = 1'b1;
          bkt_lvl_d = '0;
          bkt_bin_d = '0;
          state_d   = S_DONE;
        end else begin
          lvl_d   = lvl_q - LVL_ONE;
          state_d = S_RD;
        end
      end
      S_APPLY: begin
        wr_en_o     = 1'b1;
        wr_addr_o   = bkt_lvl_q;
        wr_data_o   = {bkt_bin_q, 1'b1};
        apply_bkt_o = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle must never reach the store, even if the FSM was mid-scan.
    if (rst) begin
      rd_en_o     = 1'b0;
      wr_en_o     = 1'b0;
      apply_bkt_o = 1'b0;
      done_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lvl_q     <= '0;
      bkt_lvl_q <= '0;
      bkt_bin_q <= '0;
      unsat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      bkt_lvl_q <= bkt_lvl_d;
      bkt_bin_q <= bkt_bin_d;
      unsat_q   <= unsat_d;
    end
  end

endmodule

// File: tb/tb_bkt_lvl_ctrl.sv
// Randomized bench for bkt_lvl_ctrl: drives decisions and scans against an array-based
// model of the level store, predicting scan result and timing directly from the store contents.
module tb_bkt_lvl_ctrl;
  localparam int WL = 16;
  localparam int WB = 10;
  localparam int WS = 11;
  localparam int ML = 64;

  logic          clk;
  logic          rst;
  logic          dec_valid_i;
  logic          dec_ready_o;
  logic [WL-1:0] dec_lvl_i;
  logic [WB-1:0] dec_bin_i;
  logic          start_i;
  logic [WL-1:0] max_lvl_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          unsat_o;
  logic [WL-1:0] bkt_lvl_o;
  logic [WB-1:0] bkt_bin_o;
  logic          apply_bkt_o;
  logic          rd_en_o;
  logic [WL-1:0] rd_addr_o;
  logic [WS-1:0] rd_data_q;
  logic          wr_en_o;
  logic [WL-1:0] wr_addr_o;
  logic [WS-1:0] wr_data_o;

  bkt_lvl_ctrl #(.WIDTH_LVL(WL), .WIDTH_BIN(WB), .WIDTH_LVL_STATES(WS), .MAX_LVL(ML)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_lvl_i(dec_lvl_i), .dec_bin_i(dec_bin_i),
    .start_i(start_i), .max_lvl_i(max_lvl_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .unsat_o(unsat_o),
    .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o), .apply_bkt_o(apply_bkt_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_q),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level store seen by the DUT; the bench can also preload or clear it directly.
  logic [WS-1:0] store [0:ML];
  int            bad_wr = 0;
  logic          pl_en  = 1'b0;
  logic          pl_clr = 1'b0;
  int            pl_addr = 0;
  logic [WS-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i <= ML; i++) store[i] <= '0;
    end else if (pl_en) begin
      store[pl_addr] <= pl_data;
    end else if (wr_en_o) begin
      if (wr_addr_o >= 1 && wr_addr_o <= ML) store[wr_addr_o] <= wr_data_o;
      else bad_wr <= bad_wr + 1;
    end
    if (rd_en_o) rd_data_q <= (rd_addr_o <= ML) ? store[rd_addr_o] : '0;
  end

  // Reference model state
  logic [WS-1:0] ref_st [0:ML];
  int            r_lvl, r_bin;
  bit            r_unsat;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic store_cmp();
    int bad;
    bad = 0;
    for (int l = 1; l <= ML; l++) if (store[l] !== ref_st[l]) bad++;
    chk("store_contents", bad + bad_wr, 0);
  endtask

  task automatic preload(input int l, input int b, input bit hb);
    logic [WB-1:0] bb;
    bb = b[WB-1:0];
    @(negedge clk);
    pl_en = 1'b1; pl_addr = l; pl_data = {bb, hb};
    @(negedge clk);
    pl_en = 1'b0;
    ref_st[l] = {bb, hb};
  endtask

  task automatic decide(input int l, input int b);
    bit            ok;
    logic [WB-1:0] bb;
    ok = (l >= 1 && l <= ML);
    bb = b[WB-1:0];
    @(negedge clk);
    dec_valid_i = 1'b1; dec_lvl_i = l[WL-1:0]; dec_bin_i = bb;
    #1;
    chk("dec_ready", dec_ready_o, 1);
    chk("dec_wr_en", wr_en_o, ok);
    chk("dec_rd_en", rd_en_o, 0);
    if (ok) begin
      chk("dec_wr_addr", wr_addr_o, l);
      chk("dec_wr_data", wr_data_o, {bb, 1'b0});
    end
    @(negedge clk);
    dec_valid_i = 1'b0;
    if (ok) ref_st[l] = {bb, 1'b0};
    store_cmp();
  endtask

  // mode: 0 plain, 1 abort, 2 reset; cyc 0 picks a random RD/CHK cycle
  task automatic scan(input int mx, input bit dd, input int dl, input int dbn,
                      input int mode, input int cyc);
    int m, found, k, t_apply, t_done, last, t_end, t_abort, t_rst, a;
    int p_lvl, p_bin;
    bit p_unsat, act, dec_ok, e_rd, e_wr;
    logic [WB-1:0] db;
    db = dbn[WB-1:0];
    m = (mx > ML) ? ML : mx;
    dec_ok = dd && dl >= 1 && dl <= ML;
    if (dec_ok) ref_st[dl] = {db, 1'b0};
    found = 0;
    for (int l = m; l >= 1; l--) begin
      if (ref_st[l][0] == 1'b0) begin
        found = l;
        break;
      end
    end
    t_apply = -1;
    if (m == 0) begin
      t_done = 1; last = 0;
    end else if (found != 0) begin
      k = m - found + 1; t_apply = 2 * k + 1; t_done = 2 * k + 2; last = 2 * k;
    end else begin
      t_done = 2 * m + 1; last = 2 * m;
    end
    if (found != 0) begin
      p_lvl = found; p_bin = int'(ref_st[found][WS-1:1]); p_unsat = 1'b0;
    end else begin
      p_lvl = 0; p_bin = 0; p_unsat = 1'b1;
    end
    t_abort = 0; t_rst = 0;
    if (last > 0 && mode != 0) begin
      a = (cyc != 0 && cyc <= last) ? cyc : int'($urandom_range(1, last));
      if (mode == 1) t_abort = a;
      else t_rst = a;
    end
    t_end = (t_abort != 0) ? t_abort : (t_rst != 0) ? t_rst : t_done;

    if (t_abort == 0 && t_rst == 0) begin
      r_lvl = p_lvl; r_bin = p_bin; r_unsat = p_unsat;
      if (found != 0) ref_st[found][0] = 1'b1;
    end else if (t_rst != 0) begin
      r_lvl = 0; r_bin = 0; r_unsat = 1'b0;
    end

    @(negedge clk);
    start_i = 1'b1; max_lvl_i = mx[WL-1:0];
    dec_valid_i = dd; dec_lvl_i = dl[WL-1:0]; dec_bin_i = db;
    #1;
    chk("c0_dec_ready", dec_ready_o, 1);
    chk("c0_rd_en", rd_en_o, 0);
    chk("c0_wr_en", wr_en_o, dec_ok);
    if (dec_ok) begin
      chk("c0_wr_addr", wr_addr_o, dl);
      chk("c0_wr_data", wr_data_o, {db, 1'b0});
    end

    for (int c = 1; c <= t_end + 1; c++) begin
      @(negedge clk);
      start_i     = (c <= t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      dec_valid_i = (c <= t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      dec_lvl_i   = WL'($urandom_range(1, ML));
      dec_bin_i   = WB'($urandom);
      abort_i     = (c == t_abort) || (c > last && c <= t_end && 1'($urandom_range(0, 1)));
      rst         = (c == t_rst);
      #1;
      act = (t_abort == 0 || c <= t_abort) && (t_rst == 0 || c < t_rst);
      if (c <= t_end) begin
        e_rd = act && c <= last && (c % 2 == 1);
        e_wr = act && c == t_apply;
        chk("rd_en", rd_en_o, e_rd);
        if (e_rd) chk("rd_addr", rd_addr_o, m - (c - 1) / 2);
        chk("wr_en", wr_en_o, e_wr);
        if (e_wr) begin
          chk("apply_wr_addr", wr_addr_o, found);
          chk("apply_wr_data", wr_data_o, {p_bin[WB-1:0], 1'b1});
        end
        chk("apply_bkt", apply_bkt_o, e_wr);
        chk("done", done_o, act && c == t_done);
        if (act && c == t_done) begin
          chk("res_lvl", bkt_lvl_o, p_lvl);
          chk("res_bin", bkt_bin_o, p_bin);
          chk("res_unsat", unsat_o, p_unsat);
        end
        if (c != t_rst) chk("busy", busy_o, 1);
      end else begin
        chk("end_busy", busy_o, 0);
        chk("end_dec_ready", dec_ready_o, 1);
        chk("end_done", done_o, 0);
        chk("end_wr_en", wr_en_o, 0);
        chk("end_lvl", bkt_lvl_o, r_lvl);
        chk("end_bin", bkt_bin_o, r_bin);
        chk("end_unsat", unsat_o, r_unsat);
      end
    end
    store_cmp();
  endtask

  initial begin
    int op, mx, mode;
    rst = 1'b1; start_i = 1'b0; max_lvl_i = '0; abort_i = 1'b0;
    dec_valid_i = 1'b1; dec_lvl_i = WL'(3); dec_bin_i = WB'(7);
    pl_clr = 1'b1;
    for (int l = 0; l <= ML; l++) ref_st[l] = '0;
    r_lvl = 0; r_bin = 0; r_unsat = 1'b0;
    repeat (2) @(negedge clk);
    pl_clr = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_apply", apply_bkt_o, 0);
    chk("rst_dec_ready", dec_ready_o, 1);
    chk("rst_unsat", unsat_o, 0);
    chk("rst_lvl", bkt_lvl_o, 0);
    chk("rst_bin", bkt_bin_o, 0);
    @(negedge clk);
    rst = 1'b0; dec_valid_i = 1'b0;
    store_cmp();

    // Found at L1 after three reads
    preload(1, 5, 1'b0); preload(2, 2, 1'b1); preload(3, 3, 1'b1);
    scan(3, 1'b0, 0, 0, 0, 0);
    // Everything already backtracked
    preload(1, 1, 1'b1); preload(2, 2, 1'b1);
    scan(2, 1'b0, 0, 0, 0, 0);
    // Empty range, then oversized max_lvl clamped to the top level
    scan(0, 1'b0, 0, 0, 0, 0);
    preload(ML, 11, 1'b0);
    scan(200, 1'b0, 0, 0, 0, 0);
    // Decision in the same cycle as start
    preload(4, 1, 1'b1);
    scan(4, 1'b1, 4, 9, 0, 0);
    // Abort in CHK, reset mid-scan, then a clean scan of the same store
    preload(5, 3, 1'b0);
    scan(5, 1'b0, 0, 0, 1, 2);
    scan(5, 1'b0, 0, 0, 2, 1);
    scan(5, 1'b0, 0, 0, 0, 0);
    // Out-of-range decisions are dropped
    decide(0, 12);
    decide(ML + 1, 13);
    decide(7, 14);

    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        decide(int'($urandom_range(0, ML + 6)), int'($urandom_range(0, 1023)));
      end else begin
        mx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ML + 1, 65535))
                                         : int'($urandom_range(0, ML + 4));
        mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
        scan(mx, 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, ML + 4)),
             int'($urandom_range(0, 1023)), mode, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
